// File: rtl/sum_operand_recover.sv
// Recovers operand B = S - A from a WIDTH+1 bit sum S and known operand A, DIGIT bits per cycle, LSB first.
// Latency: WIDTH/DIGIT cycles from accept edge to out_valid (6 for defaults); initiation interval WIDTH/DIGIT+2.
// Backpressure: in_ready only in IDLE; out_ready low holds DONE with opb_o/err_o frozen indefinitely.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_valid/in_ready request handshake carrying sum_i (WIDTH+1) and opa_i (WIDTH)
//   out_valid/out_ready result handshake carrying opb_o (WIDTH) and err_o
//   busy              state is not IDLE
//   err_sticky_o      set by any accepted result with err_o=1, cleared by rst;
//                     only built when SUM_RECOVER_ERR_STICKY_EN is defined, else tied to 0
module sum_operand_recover #(
  parameter int WIDTH = 12,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum_i,
  input  logic [WIDTH-1:0] opa_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] opb_o,
  output logic             err_o,
  output logic             busy,
  output logic             err_sticky_o
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("sum_operand_recover: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_nxt;

  logic [WIDTH-1:0] sum_q;      // low bits of S, shifted right as digits are consumed
  logic             sum_msb_q;  // S[WIDTH], kept aside for the range check
  logic [WIDTH-1:0] opa_q;
  logic             borrow_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] opb_sh_q;   // result digits enter at the top and move down

  logic [DIGIT-1:0]       diff_dig;
  logic                   borrow_nxt;
  logic [WIDTH+DIGIT-1:0] opb_cat;
  logic [WIDTH-1:0]       opb_nxt;
  logic                   last_dig;

  // Ripple subtract of one digit with incoming borrow.
  always_comb begin
    logic b;
    b        = borrow_q;
    diff_dig = '0;
    for (int i = 0; i < DIGIT; i++) begin
      diff_dig[i] = sum_q[i] ^ opa_q[i] ^ b;
      b           = (~sum_q[i] & opa_q[i]) | (~(sum_q[i] ^ opa_q[i]) & b);
    end
    borrow_nxt = b;
    opb_cat    = {diff_dig, opb_sh_q};
    opb_nxt    = opb_cat[WIDTH+DIGIT-1:DIGIT];
    last_dig   = (idx_q == IDXW'(NDIG - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_dig) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      sum_msb_q <= 1'b0;
      opa_q     <= '0;
      borrow_q  <= 1'b0;
      idx_q     <= '0;
      opb_sh_q  <= '0;
      opb_o     <= '0;
      err_o     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sum_q     <= sum_i[WIDTH-1:0];
            sum_msb_q <= sum_i[WIDTH];
            opa_q     <= opa_i;
            borrow_q  <= 1'b0;
            idx_q     <= '0;
          end
        end
        RUN: begin
          sum_q    <= sum_q >> DIGIT;
          opa_q    <= opa_q >> DIGIT;
          borrow_q <= borrow_nxt;
          opb_sh_q <= opb_nxt;
          idx_q    <= idx_q + 1'b1;
          if (last_dig) begin
            opb_o <= opb_nxt;
            // A final borrow cancels a set S[WIDTH]; any mismatch means B is out of range.
            err_o <= sum_msb_q ^ borrow_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SUM_RECOVER_ERR_STICKY_EN
  logic err_sticky_q;
  always_ff @(posedge clk) begin
    if (rst)                                        err_sticky_q <= 1'b0;
    else if (state_q == DONE && out_ready && err_o) err_sticky_q <= 1'b1;
  end
  assign err_sticky_o = err_sticky_q;
`else
  assign err_sticky_o = 1'b0;
`endif

endmodule
